wb_bus_arbiter: RTL and testbench
=================================

# wb_bus_arbiter

Round-robin Wishbone B4 classic arbiter. It shares one slave-side bus between `NUM_MASTERS` masters, for example the core's instruction bus and data bus ahead of `wb_intercon`, or a DMA master added beside the core. A grant is held for the whole `cyc` tenure, so multi-beat and locked sequences stay atomic. An optional watchdog terminates stalled cycles with `err`.

## Interface
Parameters:
- `NUM_MASTERS`, default 2: number of requesting masters, 2..8.
- `AW`, default 32: address width.
- `DW`, default 32: data width. Select width is `DW/8`.
- `TIMEOUT_CYCLES`, default 255: stall limit in cycles, 1..65535. Used only when the timeout feature is compiled in.

Ports:
- `wb_clk  in  1  single clock; all state on rising edge`
- `wb_rst_n  in  1  asynchronous, active-low reset`
- `m_adr  in  NUM_MASTERS*AW  master addresses, master i at [i*AW +: AW]`
- `m_dat  in  NUM_MASTERS*DW  master write data`
- `m_sel  in  NUM_MASTERS*DW/8  master byte selects`
- `m_we, m_cyc, m_stb  in  NUM_MASTERS  per-master control`
- `m_rdt  out  DW  read data, s_rdt broadcast to all masters`
- `m_ack, m_err  out  NUM_MASTERS  routed to the granted master only`
- `s_adr, s_dat, s_sel, s_we, s_cyc, s_stb  out  AW/DW/DW/8/1/1/1  slave-side bus`
- `s_rdt  in  DW`; `s_ack, s_err  in  1`
- `o_grant  out  NUM_MASTERS  one-hot current grant (observability)`

## Operation
- FSM states: `IDLE` and `BUSY`.
- `IDLE`:
  - If any `m_cyc` is high, select the first requester at or after `prio_ptr`, wrapping modulo `NUM_MASTERS`.
  - Register the selection into `grant` and go to `BUSY`.
  - If no `m_cyc` is high, stay in `IDLE` with `grant` = 0.
- `BUSY`:
  - Slave-side outputs are combinationally muxed from the granted master.
  - `s_ack` and `s_err` go to `m_ack[g]` and `m_err[g]`. Every other master sees 0.
  - When `m_cyc[g]` falls:
    - `s_cyc` and `s_stb` fall in the same cycle.
    - Next state is `IDLE`, `grant` is cleared, and `prio_ptr` becomes (g+1) mod `NUM_MASTERS`.
- With `grant` = 0, every slave-side output is 0 and `m_ack`/`m_err` are 0.
- `m_cyc` asserted without `m_stb` still wins arbitration and holds the bus; this is the lock behaviour.
- A master that drops `cyc` before it is granted is not served. `grant` only ever captures masters whose `cyc` is high in the `IDLE` cycle.
- Requests from non-granted masters are ignored until the bus returns to `IDLE`. No preemption.

## Timing
- Arbitration latency:
  - `m_cyc` high at edge N in `IDLE` gives `s_cyc`/`s_stb` high in cycle N+1.
  - Data-phase paths (`s_ack`, `s_err`, `s_rdt` to the master; master to slave outputs) are combinational, with 0 added cycles.
- Handover:
  - The granted master drops `cyc` in cycle M. The next master's `s_cyc` rises no earlier than cycle M+2, giving one dead `IDLE` cycle.
- Reset values, asserted asynchronously and effective immediately even mid-transfer:
  - State `IDLE`, `grant` = 0, `prio_ptr` = 0.
  - All `s_*` outputs 0; `m_ack`, `m_err`, `o_grant` 0.
- Release is synchronous to `wb_clk`.
- Simultaneous requests from `IDLE` after reset: master 0 wins, then master 1, strictly alternating while both keep requesting.
- `s_ack` and `s_err` high together: both are forwarded unchanged. The master defines priority.

## Configuration
- Macro: `WB_BUS_ARBITER_TIMEOUT_EN`.
- Defined:
  - A 16-bit stall counter counts cycles in `BUSY` with `s_stb` high and `s_ack` and `s_err` both low.
  - The counter clears on `ack`, `err`, or leaving `BUSY`.
  - On reaching `TIMEOUT_CYCLES`, the arbiter asserts `m_err[g]` for exactly one cycle, forces `s_cyc`/`s_stb` low in that cycle, and clears the counter.
  - The grant is kept until the master drops `cyc`.
- Undefined: no counter; `m_err[g]` = `s_err` only; `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `wb_arb_pkg`:
  - State encoding constants `ARB_IDLE` = 1'b0, `ARB_BUSY` = 1'b1.
  - Counter width constant `ARB_TO_W` = 16.
- Sub-module `rr_pick`:
  - Combinational round-robin picker.
  - Inputs: request vector, `prio_ptr`.
  - Outputs: one-hot grant and `valid`.
  - Reused by any future multi-master arbiter.
- The top level holds the FSM, `prio_ptr`, the mux/demux and the optional watchdog.

## Test plan
- Reset: hold `wb_rst_n` = 0 with `m_cyc` = 2'b11 -> all `s_*` = 0, `o_grant` = 0. First release edge -> `o_grant` = 2'b01 one cycle later.
- Contention: both masters issue 4 back-to-back single reads, dropping `cyc` after each ack -> grant order 0,1,0,1,0,1,0,1, with exactly one `IDLE` cycle between tenures.
- Routing: master 1 granted, slave returns `s_rdt` = 32'hDEADBEEF with `s_ack` -> `m_ack` = 2'b10, `m_rdt` = 32'hDEADBEEF. Master 0 write data never appears on `s_dat`.
- Lock: master 0 holds `cyc` for 3 beats while master 1 requests -> master 1 is granted only after master 0 drops `cyc`.
- Reset mid-transfer: assert `wb_rst_n` = 0 while `s_stb` = 1 -> `s_cyc`/`s_stb` go to 0 in the same cycle, before the next edge. After release, `prio_ptr` = 0.
- Timeout (macro defined, `TIMEOUT_CYCLES` = 8): slave never acks -> `m_err[g]` pulses at stall cycle 8, `s_stb` is low in that cycle, and the counter restarts at 0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants for the Wishbone round-robin bus arbiter: FSM state
// encoding and the watchdog counter width.
package wb_arb_pkg;

   typedef logic arb_state_t;

   localparam arb_state_t ARB_IDLE = 1'b0;
   localparam arb_state_t ARB_BUSY = 1'b1;

   localparam int ARB_TO_W = 16;

endpackage

// File: rtl/wb_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first requester at
// or after ptr_i (wrapping) as a one-hot vector, plus valid when any request is up.
module rr_pick
   import wb_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          valid_o
);

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      int idx;
      idx   = 0;
      gnt_o = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr_i) + k;
         if (idx >= N) idx = idx - N;
         if (req_i[idx]) begin
            gnt_o      = '0;
            gnt_o[idx] = 1'b1;
         end
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin Wishbone B4 classic arbiter; grant held for the
// whole cyc tenure. Optional stall watchdog via WB_BUS_ARBITER_TIMEOUT_EN.
module wb_bus_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                          wb_clk,
   input  logic                          wb_rst_n,
   input  logic [NUM_MASTERS*AW-1:0]     m_adr,
   input  logic [NUM_MASTERS*DW-1:0]     m_dat,
   input  logic [NUM_MASTERS*(DW/8)-1:0] m_sel,
   input  logic [NUM_MASTERS-1:0]        m_we,
   input  logic [NUM_MASTERS-1:0]        m_cyc,
   input  logic [NUM_MASTERS-1:0]        m_stb,
   output logic [DW-1:0]                 m_rdt,
   output logic [NUM_MASTERS-1:0]        m_ack,
   output logic [NUM_MASTERS-1:0]        m_err,
   output logic [AW-1:0]                 s_adr,
   output logic [DW-1:0]                 s_dat,
   output logic [DW/8-1:0]               s_sel,
   output logic                          s_we,
   output logic                          s_cyc,
   output logic                          s_stb,
   input  logic [DW-1:0]                 s_rdt,
   input  logic                          s_ack,
   input  logic                          s_err,
   output logic [NUM_MASTERS-1:0]        o_grant
);

   localparam int SW = DW / 8;
   localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_masters
      $error("wb_bus_arbiter: NUM_MASTERS must be 2..8");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << ARB_TO_W)) begin : g_bad_timeout
      $error("wb_bus_arbiter: TIMEOUT_CYCLES must be 1..65535");
   end

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [PW-1:0]          ptr_q, ptr_d;
   logic [NUM_MASTERS-1:0] pick_gnt;
   logic                   pick_vld;
   logic [PW-1:0]          gidx;
   logic                   cyc_g;
   logic                   stb_g;
   logic                   to_fire;

   rr_pick #(.N(NUM_MASTERS), .PW(PW)) u_pick (
      .req_i   (m_cyc),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .valid_o (pick_vld)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) gidx = PW'(i);
      end
   end

   assign cyc_g = |(m_cyc & grant_q);
   assign stb_g = |(m_stb & m_cyc & grant_q);

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         ARB_IDLE: begin
            grant_d = '0;
            if (pick_vld) begin
               state_d = ARB_BUSY;
               grant_d = pick_gnt;
            end
         end
         default: begin
            if (!cyc_g) begin
               state_d = ARB_IDLE;
               grant_d = '0;
               ptr_d   = (gidx == PW'(NUM_MASTERS - 1)) ? '0 : gidx + PW'(1);
            end
         end
      endcase
   end

   // A zero grant selects nothing, so every slave-side output falls to 0.
   always_comb begin
      s_adr = '0;
      s_dat = '0;
      s_sel = '0;
      s_we  = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (grant_q[i]) begin
            s_adr = m_adr[i*AW +: AW];
            s_dat = m_dat[i*DW +: DW];
            s_sel = m_sel[i*SW +: SW];
            s_we  = m_we[i];
         end
      end
      s_cyc   = cyc_g & ~to_fire;
      s_stb   = stb_g & ~to_fire;
      m_ack   = grant_q & {NUM_MASTERS{s_ack}};
      m_err   = grant_q & {NUM_MASTERS{s_err | to_fire}};
      m_rdt   = s_rdt;
      o_grant = grant_q;
   end

`ifdef WB_BUS_ARBITER_TIMEOUT_EN
   logic [ARB_TO_W-1:0] to_q, to_d;
   logic                stall;

   assign stall   = (state_q == ARB_BUSY) && stb_g && !s_ack && !s_err;
   assign to_fire = stall && (to_q == ARB_TO_W'(TIMEOUT_CYCLES - 1));
   assign to_d    = (stall && !to_fire) ? to_q + ARB_TO_W'(1) : '0;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) to_q <= '0;
      else           to_q <= to_d;
   end
`else
   assign to_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed scenarios plus randomized
// traffic, compared every cycle against a tenure-level ownership model.
`timescale 1ns/1ps
module tb_wb_bus_arbiter;

   localparam int N   = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int TCY = 8;
`ifdef WB_BUS_ARBITER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            wb_clk = 1'b0;
   logic            wb_rst_n = 1'b0;
   logic [N*AW-1:0] m_adr = '0;
   logic [N*DW-1:0] m_dat = '0;
   logic [N*SW-1:0] m_sel = '0;
   logic [N-1:0]    m_we = '0, m_cyc = '0, m_stb = '0;
   logic [DW-1:0]   m_rdt;
   logic [N-1:0]    m_ack, m_err;
   logic [AW-1:0]   s_adr;
   logic [DW-1:0]   s_dat;
   logic [SW-1:0]   s_sel;
   logic            s_we, s_cyc, s_stb;
   logic [DW-1:0]   s_rdt = '0;
   logic            s_ack = 1'b0, s_err = 1'b0;
   logic [N-1:0]    o_grant;

   always #5 wb_clk = ~wb_clk;

   wb_bus_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TCY)) dut (
      .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
      .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel), .m_we(m_we),
      .m_cyc(m_cyc), .m_stb(m_stb), .m_rdt(m_rdt), .m_ack(m_ack), .m_err(m_err),
      .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel), .s_we(s_we),
      .s_cyc(s_cyc), .s_stb(s_stb), .s_rdt(s_rdt), .s_ack(s_ack), .s_err(s_err),
      .o_grant(o_grant)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: who owns the bus (-1 = nobody), where the next search
   // starts, and how many consecutive stalled beats the owner has accumulated.
   int own   = -1;
   int ptr   = 0;
   int stall = 0;

   always @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         own = -1; ptr = 0; stall = 0;
      end else if (own < 0) begin
         for (int k = 0; k < N; k++)
            if (own < 0 && m_cyc[(ptr + k) % N]) own = (ptr + k) % N;
      end else if (!m_cyc[own]) begin
         ptr = (own + 1) % N; own = -1; stall = 0;
      end else if (m_stb[own] && !s_ack && !s_err) begin
         stall = (stall + 1 == TCY) ? 0 : stall + 1;
      end else begin
         stall = 0;
      end
   end

   always @(negedge wb_clk) begin : cmp
      logic          fire;
      logic          e_cyc, e_stb, e_we;
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_dat;
      logic [SW-1:0] e_sel;
      logic [N-1:0]  e_ack, e_err, e_gnt;
      fire = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_adr = '0; e_dat = '0; e_sel = '0; e_ack = '0; e_err = '0; e_gnt = '0;
      if (own >= 0) begin
         fire  = TO_EN && m_cyc[own] && m_stb[own] && !s_ack && !s_err && (stall + 1 == TCY);
         e_cyc = m_cyc[own] && !fire;
         e_stb = m_cyc[own] && m_stb[own] && !fire;
         e_we  = m_we[own];
         e_adr = m_adr[own*AW +: AW];
         e_dat = m_dat[own*DW +: DW];
         e_sel = m_sel[own*SW +: SW];
         e_ack[own] = s_ack;
         e_err[own] = s_err | fire;
         e_gnt[own] = 1'b1;
      end
      chk("s_cyc", s_cyc, e_cyc);
      chk("s_stb", s_stb, e_stb);
      chk("s_we", s_we, e_we);
      chk("s_adr", s_adr, e_adr);
      chk("s_dat", s_dat, e_dat);
      chk("s_sel", s_sel, e_sel);
      chk("m_ack", m_ack, e_ack);
      chk("m_err", m_err, e_err);
      chk("m_rdt", m_rdt, s_rdt);
      chk("o_grant", o_grant, e_gnt);
   end

   // Master agents and tenure recording.
   int ten_left[N], beats[N], bcnt[N];
   logic [N-1:0] ack_seen = '0;
   int order_q[$], gap_q[$];
   logic [N-1:0] prev_g = '0;
   int idle_run = 0, acks0 = 0;
   bit seen_ten = 0;

   task automatic rand_beat(input int i);
      m_adr[i*AW +: AW] = $urandom;
      m_dat[i*DW +: DW] = $urandom;
      m_sel[i*SW +: SW] = SW'($urandom);
      m_we[i]           = 1'($urandom);
   endtask

   task automatic agent_step();
      for (int i = 0; i < N; i++) begin
         if (m_cyc[i]) begin
            if (ack_seen[i]) begin
               bcnt[i]--;
               if (bcnt[i] == 0) begin
                  m_cyc[i] = 1'b0; m_stb[i] = 1'b0; ten_left[i]--;
               end else rand_beat(i);
            end
         end else if (ten_left[i] > 0) begin
            m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
            bcnt[i]  = (beats[i] > 0) ? beats[i] : $urandom_range(1, 4);
            rand_beat(i);
         end
      end
   endtask

   task automatic record();
      if (o_grant != '0) begin
         if (prev_g == '0) begin
            order_q.push_back(o_grant[1] ? 1 : 0);
            if (seen_ten) gap_q.push_back(idle_run);
            seen_ten = 1;
         end
         idle_run = 0;
      end else idle_run++;
      if (o_grant == 2'b01 && m_ack[0]) acks0++;
      prev_g = o_grant;
   endtask

   task automatic clear_rec();
      order_q.delete(); gap_q.delete();
      idle_run = 0; acks0 = 0; seen_ten = 0;
   endtask

   // mmode: 0 hold, 1 agents, 2 random; smode: 0 hold, 1 ack, 2 ack/err, 3 random, 4 silent
   task automatic cycle(input int mmode, input int smode);
      @(posedge wb_clk); #1;
      if (mmode == 1) agent_step();
      else if (mmode == 2) begin
         m_cyc = N'($urandom); m_stb = N'($urandom);
         for (int i = 0; i < N; i++) rand_beat(i);
      end
      #1;
      s_rdt = $urandom;
      case (smode)
         1: begin s_ack = s_stb && ($urandom_range(0, 99) < 75); s_err = 1'b0; end
         2: begin
            s_ack = s_stb && ($urandom_range(0, 99) < 60);
            s_err = s_stb && !s_ack && ($urandom_range(0, 99) < 15);
         end
         3: begin s_ack = 1'($urandom); s_err = ($urandom_range(0, 99) < 20); end
         4: begin s_ack = 1'b0; s_err = 1'b0; end
         default: ;
      endcase
      @(negedge wb_clk);
      ack_seen = m_ack | m_err;
      record();
   endtask

   task automatic run_agents(input string name, input int budget);
      bit done;
      done = 0;
      for (int c = 0; c < budget && !done; c++) begin
         cycle(1, (name == "rand") ? 2 : 1);
         done = (ten_left[0] == 0) && (ten_left[1] == 0) && (m_cyc == '0) && (o_grant == '0);
      end
      chk({name, "_done"}, done, 1'b1);
   endtask

   initial begin
      #500us;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      for (int i = 0; i < N; i++) begin ten_left[i] = 0; beats[i] = 1; bcnt[i] = 0; end

      // Reset held with both masters requesting.
      m_cyc = 2'b11; m_stb = 2'b11;
      repeat (3) cycle(0, 0);
      chk("rst_s_cyc", s_cyc, 1'b0);
      chk("rst_grant", o_grant, 2'b00);
      @(posedge wb_clk); #1 wb_rst_n = 1'b1;
      @(negedge wb_clk);
      chk("rel_grant_pre", o_grant, 2'b00);
      @(negedge wb_clk);
      chk("rel_grant", o_grant, 2'b01);

      // Routing: hand over to master 1 and return read data.
      @(posedge wb_clk); #1;
      m_cyc = 2'b10; m_stb = 2'b10;
      m_dat = {32'h2222_2222, 32'h1111_1111};
      @(negedge wb_clk);
      repeat (2) cycle(0, 0);
      chk("route_grant", o_grant, 2'b10);
      @(posedge wb_clk); #2;
      s_rdt = 32'hDEAD_BEEF; s_ack = 1'b1;
      @(negedge wb_clk);
      chk("route_ack", m_ack, 2'b10);
      chk("route_rdt", m_rdt, 32'hDEAD_BEEF);
      chk("route_dat", s_dat, 32'h2222_2222);

      // Asynchronous reset in the middle of a transfer.
      @(posedge wb_clk); #1 s_ack = 1'b0;
      #2 chk("mid_pre_stb", s_stb, 1'b1);
      wb_rst_n = 1'b0;
      #1;
      chk("mid_s_cyc", s_cyc, 1'b0);
      chk("mid_s_stb", s_stb, 1'b0);
      chk("mid_grant", o_grant, 2'b00);
      m_cyc = '0; m_stb = '0;
      repeat (2) cycle(0, 0);
      @(posedge wb_clk); #1 wb_rst_n = 1'b1;
      repeat (2) cycle(0, 0);

      // Contention: 4 single-beat tenures each, must alternate from master 0.
      clear_rec();
      ten_left[0] = 4; ten_left[1] = 4; beats[0] = 1; beats[1] = 1;
      run_agents("cont", 300);
      chk("cont_n", order_q.size(), 8);
      foreach (order_q[k]) chk($sformatf("cont_order%0d", k), order_q[k], k % 2);
      foreach (gap_q[k]) chk($sformatf("cont_gap%0d", k), gap_q[k], 1);

      // Lock: master 0 keeps cyc for 3 beats while master 1 waits.
      clear_rec();
      ten_left[0] = 1; ten_left[1] = 1; beats[0] = 3; beats[1] = 1;
      run_agents("lock", 200);
      chk("lock_n", order_q.size(), 2);
      foreach (order_q[k]) chk($sformatf("lock_order%0d", k), order_q[k], k);
      chk("lock_beats0", acks0, 3);
      foreach (gap_q[k]) chk($sformatf("lock_gap%0d", k), gap_q[k], 1);

`ifdef WB_BUS_ARBITER_TIMEOUT_EN
      // Watchdog: silent slave, error pulse every TCY stalled cycles.
      @(posedge wb_clk); #1;
      m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0; s_err = 1'b0;
      @(negedge wb_clk);
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         cycle(0, 4);
         if (o_grant[0]) cnt++;
         if (m_err[0]) break;
      end
      chk("to_first", cnt, TCY);
      chk("to_stb_low", s_stb, 1'b0);
      chk("to_cyc_low", s_cyc, 1'b0);
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         cycle(0, 4);
         cnt++;
         if (m_err[0]) break;
      end
      chk("to_restart", cnt, TCY);
      @(posedge wb_clk); #1 m_cyc = '0; m_stb = '0;
      repeat (3) cycle(0, 0);
`endif

      // Randomized well-behaved traffic with random burst lengths and errors.
      clear_rec();
      ten_left[0] = $urandom_range(3, 8); ten_left[1] = $urandom_range(3, 8);
      beats[0] = 0; beats[1] = 0;
      run_agents("rand", 2000);

      // Unconstrained random pin activity.
      for (int c = 0; c < 400; c++) cycle(2, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
